lutram_pattern_checker: RTL and testbench

- Parametrised, self-checking successor to the single-bit LUTRAM exerciser.
- Sweeps an inferred distributed RAM of 2^A_WIDTH x D_WIDTH through three phases, using a selectable data pattern:
  - clear
  - write pattern
  - read-back-and-compare
- Reports pass/fail, error count and first failing address.
- All logic runs on one clock, advancing on a divided enable tick; there is no derived clock.

---
 rtl/lutram_pattern_checker.sv | 173 +++++++++++++++++
 tb/tb_lutram_pattern_checker.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lutram_pattern_checker.sv
// lutram_pattern_checker: sweeps an inferred distributed RAM through clear, write-pattern
// and read-back-compare phases on a divided tick, reporting pass/fail, error count and
// the first failing address.
// Optional macro LUTRAM_INJECT_EN: inverts bit 0 of the word written at INJECT_ADDR.
module lutram_pattern_checker #(
  parameter int          A_WIDTH         = 5,
  parameter int          D_WIDTH         = 1,
  parameter logic [31:0] DIV_COUNTER_END = 32'h00FF_FFFF,
  parameter int          INJECT_ADDR     = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH:0]   err_cnt_o,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic [2:0]         state_o,
  output logic [D_WIDTH-1:0] q_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [A_WIDTH-1:0] A_ONE = 1;
  localparam logic [A_WIDTH:0]   E_ONE = 1;

  logic [31:0]        div_cnt;
  logic               tick, div_hit;
  logic [2:0]         state, state_nxt;
  logic [A_WIDTH-1:0] addr, addr_nxt;
  logic [1:0]         mode;
  logic               pend, accept, last, we, mism;
  logic [D_WIDTH-1:0] pat, wdata;
  logic [A_WIDTH:0]   err_cnt;
  logic [A_WIDTH-1:0] first_err;
  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  // Expected data word for a given pattern mode and address.
  function automatic logic [D_WIDTH-1:0] pattern(input logic [1:0] m, input logic [A_WIDTH-1:0] a);
    logic [A_WIDTH+D_WIDTH-1:0] ext;
    logic [D_WIDTH-1:0]         p;
    ext = {{D_WIDTH{1'b0}}, a};
    p   = '0;
    case (m)
      2'd0:    p = {D_WIDTH{a[0]}};
      2'd1:    p = ext[D_WIDTH-1:0];
      2'd2:    p = ~ext[D_WIDTH-1:0];
      default: for (int i = 0; i < D_WIDTH; i++) p[i] = a[0] ^ i[0];
    endcase
    return p;
  endfunction

  // A zero end value means a tick every cycle; skip the always-true compare in that case.
  generate
    if (DIV_COUNTER_END == 32'd0) begin : g_nodiv
      assign div_hit = 1'b1;
    end else begin : g_div
      assign div_hit = (div_cnt >= DIV_COUNTER_END);
    end
  endgenerate

  assign accept = tick && pend && (state == S_IDLE || state == S_DONE);
  assign last   = &addr;
  assign we     = (state == S_CLEAR) || (state == S_WRITE);
  assign pat    = pattern(mode, addr);
  assign q_o    = mem[addr];
  assign mism   = (state == S_READ) && (q_o != pat);

  // Clock divider: registered one-cycle tick, counter restarts on the hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_hit) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
      tick    <= 1'b0;
    end
  end

  // Start request capture; acceptance wins so a held start cannot re-arm the same run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                             pend <= 1'b0;
    else if (accept)                                         pend <= 1'b0;
    else if (start_i && (state == S_IDLE || state == S_DONE)) pend <= 1'b1;
  end

  // Write data: zero in CLEAR, pattern in WRITE (optionally corrupted at one address).
  always_comb begin
    wdata = (state == S_WRITE) ? pat : '0;
`ifdef LUTRAM_INJECT_EN
    if (state == S_WRITE && addr == INJECT_ADDR[A_WIDTH-1:0]) wdata[0] = ~wdata[0];
`endif
  end

  // Distributed RAM: synchronous write, asynchronous read, contents not reset.
  always_ff @(posedge clk_i) begin
    if (tick && we) mem[addr] <= wdata;
  end

  // FSM state and sweep address register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  // FSM next state; everything advances only on tick.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    if (tick) begin
      case (state)
        S_IDLE, S_DONE: if (pend) begin
          state_nxt = S_CLEAR;
          addr_nxt  = '0;
        end
        S_CLEAR: begin
          addr_nxt = addr + A_ONE;
          if (last) state_nxt = S_WRITE;
        end
        S_WRITE: begin
          addr_nxt = addr + A_ONE;
          if (last) state_nxt = S_READ;
        end
        S_READ: begin
          addr_nxt = addr + A_ONE;
          if (last) state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
          addr_nxt  = '0;
        end
      endcase
    end
  end

  // Run bookkeeping: mode latch, saturating error count, first failing address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode      <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (accept) begin
      mode      <= mode_i;
      err_cnt   <= '0;
      first_err <= '0;
    end else if (tick && mism) begin
      if (~&err_cnt)     err_cnt   <= err_cnt + E_ONE;
      if (err_cnt == '0) first_err <= addr;
    end
  end

  // FSM outputs.
  always_comb begin
    busy_o           = (state == S_CLEAR) || (state == S_WRITE) || (state == S_READ);
    done_o           = (state == S_DONE);
    pass_o           = (state == S_DONE) && (err_cnt == '0);
    state_o          = state;
    err_cnt_o        = err_cnt;
    first_err_addr_o = first_err;
  end
endmodule

// File: tb/tb_lutram_pattern_checker.sv
// tb_lutram_pattern_checker: randomized runs checked against a timeline/pattern model.
module tb_lutram_pattern_checker;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int P     = 3;   // tick period in clk cycles
  localparam int INJ   = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          busy_o, done_o, pass_o;
  logic [AW:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic [2:0]    state_o;
  logic [DW-1:0] q_o;

  lutram_pattern_checker #(
    .A_WIDTH(AW), .D_WIDTH(DW), .DIV_COUNTER_END(32'(P - 1)), .INJECT_ADDR(INJ)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .state_o(state_o), .q_o(q_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, edge_n = 0, prev_st = 0;
  bit inj_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference pattern from the mode rules, plain integer arithmetic.
  function automatic int pat(input int m, input int a);
    int mask, v;
    mask = (1 << DW) - 1;
    v = 0;
    case (m)
      0: v = (a % 2 == 1) ? mask : 0;
      1: v = a & mask;
      2: v = mask - (a & mask);
      default: for (int i = 0; i < DW; i++) if (((a % 2) + i) % 2 == 1) v += (1 << i);
    endcase
    return v;
  endfunction

  // One clock: count the rising edge, return at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk_i);
    edge_n++;
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_err"}, err_cnt_o, 0);
    chk({tag, "_fea"}, first_err_addr_o, 0);
  endtask

  // One run: idle 'pre' cycles, start, follow the expected phase timeline.
  // hold_n: keep start high until tick index hold_n; abort_n: assert reset at tick index abort_n.
  task automatic run(input int m, input int pre, input int hold_n, input int abort_n);
    int e0, ea, n, est, a, expq;
    for (int i = 0; i < pre; i++) begin
      step();
      chk("idle_state", state_o, prev_st);
      chk("idle_done", done_o, prev_st == 4);
    end
    start_i = 1'b1;
    mode_i  = 2'(m);
    step();
    e0 = edge_n;
    // First FSM-advancing edge strictly after the start was captured.
    ea = e0 + 1;
    while ((ea - 1) % P != 0) ea++;
    for (int k = 0; k < 1000; k++) begin
      n   = (edge_n >= ea) ? (edge_n - ea) / P + 1 : 0;
      est = (n == 0) ? prev_st : (n <= DEPTH) ? 1 : (n <= 2*DEPTH) ? 2 : (n <= 3*DEPTH) ? 3 : 4;
      chk("state", state_o, est);
      chk("busy", busy_o, (n >= 1 && n <= 3*DEPTH));
      chk("done", done_o, est == 4);
      if (est == 2) chk("q_write", q_o, 0);
      if (est == 3) begin
        a    = n - 2*DEPTH - 1;
        expq = pat(m, a);
        if (inj_on && a == INJ) expq = expq ^ 1;
        chk("q_read", q_o, expq);
      end
      if (abort_n != 0 && n == abort_n) begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_hold_state", state_o, 0);
        rst_ni  = 1'b1;
        edge_n  = 0;
        prev_st = 0;
        return;
      end
      if (n >= hold_n) start_i = 1'b0;
      if (n >= 1) mode_i = 2'($urandom_range(0, 3));
      if (n >= 3*DEPTH + 1 + 10) break;
      step();
    end
    chk("end_state", state_o, 4);
    chk("end_err", err_cnt_o, inj_on ? 1 : 0);
    chk("end_fea", first_err_addr_o, inj_on ? INJ : 0);
    chk("end_pass", pass_o, inj_on ? 0 : 1);
    chk("end_busy", busy_o, 0);
    prev_st = 4;
  endtask

  initial begin
`ifdef LUTRAM_INJECT_EN
    inj_on = 1'b1;
`else
    inj_on = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    edge_n = 0;
    run(1, 2, 0, 0);
    run(2, 0, 0, 0);
    run(3, 1, 0, 0);
    run(0, 3, 0, 0);
    for (int r = 0; r < 3; r++) run(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 0, 0);
    run(1, 1, 2*DEPTH - 2, 0);          // start held through CLEAR and into WRITE
    run(2, 4, 0, 0);                    // restart from DONE after the held run
    run(2, 1, 0, 2*DEPTH - 5);          // reset in WRITE at address 10
    run(0, 2, 0, 0);                    // fresh run after abort
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
